otg_hpi_master: RTL

Hardware initiator for the CY7C67200 host-port interface (HPI). Replaces software bit-banging of the HPI address/data/strobe PIOs: the Nios writes a 16-bit EZ-OTG memory address, optional write data and a command over an Avalon-MM slave. The block then runs the two-access HPI sequence: an ADDRESS-port write followed by a DATA-port read or write. It sits between the Nios Avalon fabric and the top-level OTG_* pins.

---
 rtl/otg_hpi_master.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/otg_hpi_master.sv
// Avalon-MM slave that runs the CY7C67200 HPI two-access sequence
// (ADDRESS-port write, then DATA-port read or write) on registered pins.
module otg_hpi_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  otg_hpi_address,
  output logic        otg_hpi_cs_n,
  output logic        otg_hpi_r_n,
  output logic        otg_hpi_w_n,
  output logic [15:0] otg_hpi_data_out,
  output logic        otg_hpi_data_oe,
  input  logic [15:0] otg_hpi_data_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD, S_D_SETUP, S_D_STROBE, S_D_HOLD
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] C_SETUP  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_STROBE = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_memaddr, r_wdata, r_rdata;
  logic          r_dir, r_done;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_wr, w_idle, w_start, w_cap, w_last;
  logic          w_aph, w_dph, w_cs_n_nxt, w_oe_nxt, w_r_n_nxt, w_w_n_nxt;
  logic [1:0]    w_addr_nxt;
  logic [15:0]   w_dout_nxt;
  logic          w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_idle      = (r_state == S_IDLE);
  assign w_start     = w_wr & w_idle & (address == 2'd2) & writedata[0];
  assign w_last      = (r_cnt == '0);
  assign w_cap       = (r_state == S_D_STROBE) & w_last & r_dir;
  assign w_unused_wd = ^writedata[31:16];

  // Shared down-counter: reloaded with (length-1) on entry, state exits at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CW'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (w_start) begin w_state_nxt = S_A_SETUP; w_cnt_nxt = C_SETUP; end
      end
      S_A_SETUP:  if (w_last) begin w_state_nxt = S_A_STROBE; w_cnt_nxt = C_STROBE; end
      S_A_STROBE: if (w_last) begin w_state_nxt = S_A_HOLD;   w_cnt_nxt = C_HOLD;   end
      S_A_HOLD:   if (w_last) begin w_state_nxt = S_D_SETUP;  w_cnt_nxt = C_SETUP;  end
      S_D_SETUP:  if (w_last) begin w_state_nxt = S_D_STROBE; w_cnt_nxt = C_STROBE; end
      S_D_STROBE: if (w_last) begin w_state_nxt = S_D_HOLD;   w_cnt_nxt = C_HOLD;   end
      S_D_HOLD:   if (w_last) begin w_state_nxt = S_IDLE;     w_cnt_nxt = '0;       end
      default: begin w_state_nxt = S_IDLE; w_cnt_nxt = '0; end
    endcase
  end

  // Pin values decoded from the next state so they register with it.
  always_comb begin
    w_aph      = (w_state_nxt == S_A_SETUP) | (w_state_nxt == S_A_STROBE) |
                 (w_state_nxt == S_A_HOLD);
    w_dph      = (w_state_nxt == S_D_SETUP) | (w_state_nxt == S_D_STROBE) |
                 (w_state_nxt == S_D_HOLD);
    w_cs_n_nxt = ~(w_aph | w_dph);
    w_addr_nxt = w_aph ? 2'd2 : 2'd0;
    w_oe_nxt   = w_aph | (w_dph & ~r_dir);
    w_dout_nxt = 16'h0;
    if (w_aph)               w_dout_nxt = r_memaddr;
    else if (w_dph & ~r_dir) w_dout_nxt = r_wdata;
    w_w_n_nxt  = ~((w_state_nxt == S_A_STROBE) | ((w_state_nxt == S_D_STROBE) & ~r_dir));
    w_r_n_nxt  = ~((w_state_nxt == S_D_STROBE) & r_dir);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      otg_hpi_address  <= 2'd0;
      otg_hpi_cs_n     <= 1'b1;
      otg_hpi_r_n      <= 1'b1;
      otg_hpi_w_n      <= 1'b1;
      otg_hpi_data_out <= 16'h0;
      otg_hpi_data_oe  <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      otg_hpi_address  <= w_addr_nxt;
      otg_hpi_cs_n     <= w_cs_n_nxt;
      otg_hpi_r_n      <= w_r_n_nxt;
      otg_hpi_w_n      <= w_w_n_nxt;
      otg_hpi_data_out <= w_dout_nxt;
      otg_hpi_data_oe  <= w_oe_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_memaddr <= 16'h0;
      r_wdata   <= 16'h0;
      r_rdata   <= 16'h0;
      r_dir     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_wr && w_idle && address == 2'd0) r_memaddr <= writedata[15:0];
      if (w_wr && w_idle && address == 2'd1) r_wdata   <= writedata[15:0];
      if (w_start) begin
        r_dir  <= writedata[1];
        r_done <= 1'b0;
      end else if (r_state == S_D_HOLD && w_state_nxt == S_IDLE) begin
        r_done <= 1'b1;
      end
      if (w_cap) r_rdata <= otg_hpi_data_in;
    end
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      2'd0: readdata = {16'h0, r_memaddr};
      2'd1: readdata = {16'h0, r_wdata};
      2'd2: readdata = {30'h0, r_done, ~w_idle};
      2'd3: readdata = {16'h0, r_rdata};
      default: readdata = 32'h0;
    endcase
  end

endmodule
